mem_bus_arbiter: RTL and testbench

- Shares one single-ported memory bus between the pipeline's instruction-fetch port and its MEM-stage data port.
- Holds and sequences each transaction until the bus acknowledges it.
- Generates per-port stall requests, which the hazard unit ORs into stallF and stallM.
- Data port has priority; a consecutive-grant limit prevents instruction-fetch starvation.

---
 rtl/arb_pkg.sv | 26 ++
 rtl/arb_timeout_cnt.sv | 29 ++
 rtl/mem_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared definitions for the memory bus arbiter.
//   - arbState_t : arbiter FSM state encoding
//   - ERR_WORD   : read data returned on a timed-out transaction
//   - *_DEF      : default widths / limits used by the top-level parameters
//   - satInc     : saturating increment used by the data run counter
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arbState_t;

  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

  localparam int ADDR_W_DEF       = 32;
  localparam int DATA_W_DEF       = 32;
  localparam int MAX_DATA_RUN_DEF = 4;
  localparam int TIMEOUT_DEF      = 16;

  // Saturating increment of a small counter; limit is passed in at full int width.
  function automatic int satInc(input int cur, input int limit);
    return (cur >= limit) ? limit : cur + 1;
  endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// arb_timeout_cnt: clear/enable cycle counter with terminal-count flag.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : count this cycle
//   tc       : high while the count equals LIMIT-1, i.e. during the
//              LIMIT-th enabled cycle after a clear. Holds there (saturates).
module arb_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            cnt <= '0;
    else if (clr)       cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-ported memory bus between the
// instruction-fetch port and the MEM-stage data port.
//
// Ports
//   clk, rst                    clock, async active-high reset
//   inst_req/inst_addr          fetch request (held until inst_ready)
//   inst_rdata/inst_ready       fetched word + 1-cycle completion pulse
//   inst_stall                  inst_req & ~inst_ready
//   data_req/we/addr/wdata      load/store request (held until data_ready)
//   data_rdata/data_ready       load data + 1-cycle completion pulse
//   data_stall                  data_req & ~data_ready
//   bus_req/we/addr/wdata       registered bus transaction, stable until ack
//   bus_rdata/bus_ack           bus response
//   bus_err                     timeout abort pulse
//
// Data port has priority, but after MAX_DATA_RUN consecutive data grants
// with a fetch waiting, the fetch is granted next.
//
// Optional build macro ARB_TIMEOUT_EN: aborts a grant after TIMEOUT cycles
// without bus_ack, pulsing bus_err and returning ERR_WORD. Without it the
// arbiter waits indefinitely and bus_err is tied low.
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_DATA_RUN = MAX_DATA_RUN_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch port
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_ready,
  output logic              inst_stall,
  // data port
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ready,
  output logic              data_stall,
  // memory bus
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err
);

  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);

  if (MAX_DATA_RUN < 1 || TIMEOUT < 2) begin : gBadCfg
    $error("mem_bus_arbiter: MAX_DATA_RUN must be >= 1 and TIMEOUT >= 2");
  end

  arbState_t         state, nextState;
  logic [RUN_W-1:0]  runCnt;
  logic              grantI, grantD;
  logic              inGrant;
  logic              timeoutHit;
  logic              done;
  logic              runFull;
  logic [DATA_W-1:0] rdataSel;

  assign inGrant = (state == GRANT_I) || (state == GRANT_D);
  assign runFull = (runCnt == RUN_W'(MAX_DATA_RUN));

  // A grant finishes on bus_ack, or on timeout when that feature is built in.
  assign done = inGrant && (bus_ack || timeoutHit);

`ifdef ARB_TIMEOUT_EN
  logic toTc;

  arb_timeout_cnt #(.LIMIT(TIMEOUT)) uTimeout (
    .clk (clk),
    .rst (rst),
    .clr (grantI || grantD),
    .en  (inGrant),
    .tc  (toTc)
  );

  assign timeoutHit = inGrant && toTc;
  // A same-cycle ack beats the timeout: real data, no error.
  assign bus_err    = timeoutHit && !bus_ack;
  assign rdataSel   = bus_ack ? bus_rdata : DATA_W'(ERR_WORD);
`else
  assign timeoutHit = 1'b0;
  assign bus_err    = 1'b0;
  assign rdataSel   = bus_rdata;
`endif

  // Ready goes only to the port that owns the bus; rdata is meaningful only with ready.
  assign inst_ready = (state == GRANT_I) && done;
  assign data_ready = (state == GRANT_D) && done;
  assign inst_rdata = rdataSel;
  assign data_rdata = rdataSel;
  assign inst_stall = inst_req && !inst_ready;
  assign data_stall = data_req && !data_ready;

  // Next-state / grant decode
  always_comb begin
    nextState = state;
    grantI    = 1'b0;
    grantD    = 1'b0;
    case (state)
      IDLE: begin
        if (data_req && !(inst_req && runFull)) begin
          grantD    = 1'b1;
          nextState = GRANT_D;
        end else if (inst_req) begin
          grantI    = 1'b1;
          nextState = GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        if (done) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Bus outputs are captured at the grant edge and then ignore the requester
  // until completion, so a requester changing its inputs mid-flight is harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else if (grantD) begin
      bus_req   <= 1'b1;
      bus_we    <= data_we;
      bus_addr  <= data_addr;
      bus_wdata <= data_wdata;
    end else if (grantI) begin
      bus_req   <= 1'b1;
      bus_we    <= 1'b0;
      bus_addr  <= inst_addr;
    end else if (done) begin
      bus_req   <= 1'b0;
    end
  end

  // Counts data grants made while a fetch is waiting; any fetch grant, or a
  // data grant with no fetch waiting, starts the run over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      runCnt <= '0;
    end else if (grantI) begin
      runCnt <= '0;
    end else if (grantD) begin
      if (inst_req) runCnt <= RUN_W'(satInc(int'(runCnt), MAX_DATA_RUN));
      else          runCnt <= '0;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXR = 4;
  localparam int TO   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_rdata;
  logic          inst_ready, inst_stall;
  logic          data_req, data_we;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata, data_rdata;
  logic          data_ready, data_stall;
  logic          bus_req, bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;
  logic          bus_ack, bus_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_RUN(MAXR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_ready(inst_ready), .inst_stall(inst_stall),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_ready(data_ready), .data_stall(data_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .bus_err(bus_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    inst_req = 0; inst_addr = '0;
    data_req = 0; data_we = 0; data_addr = '0; data_wdata = '0;
    bus_ack = 0; bus_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    idleInputs();
    step(); step();
    #1;
    checks++;
    if (bus_req !== 1'b0 || bus_we !== 1'b0) begin
      failures++; $display("FAIL reset_ctl: bus_req=%b bus_we=%b want 0 0", bus_req, bus_we);
    end
    checks++;
    if (bus_addr !== '0 || bus_wdata !== '0) begin
      failures++; $display("FAIL reset_bus: addr=%h wdata=%h want 0 0", bus_addr, bus_wdata);
    end
    checks++;
    if (inst_ready !== 1'b0 || data_ready !== 1'b0 || bus_err !== 1'b0) begin
      failures++; $display("FAIL reset_ready: ir=%b dr=%b err=%b want 0 0 0", inst_ready, data_ready, bus_err);
    end
    step();
    rst = 0;
  endtask

  task automatic test_single_fetch();
    step();
    inst_req = 1; inst_addr = 32'hBFC00000;
    #1;
    checks++;
    if (inst_stall !== 1'b1 || bus_req !== 1'b0) begin
      failures++; $display("FAIL fetch_req_cycle: stall=%b bus_req=%b want 1 0", inst_stall, bus_req);
    end
    step();
    #1;
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'hBFC00000 || bus_we !== 1'b0 || inst_ready !== 1'b0) begin
      failures++;
      $display("FAIL fetch_grant: req=%b addr=%h we=%b ready=%b want 1 bfc00000 0 0", bus_req, bus_addr, bus_we, inst_ready);
    end
    step();
    bus_ack = 1; bus_rdata = 32'h24080001;
    #1;
    checks++;
    if (inst_ready !== 1'b1 || inst_rdata !== 32'h24080001 || inst_stall !== 1'b0 || bus_we !== 1'b0) begin
      failures++;
      $display("FAIL fetch_done: ready=%b rdata=%h stall=%b we=%b want 1 24080001 0 0", inst_ready, inst_rdata, inst_stall, bus_we);
    end
    checks++;
    if (data_ready !== 1'b0) begin
      failures++; $display("FAIL fetch_no_dready: data_ready=%b want 0", data_ready);
    end
    step();
    inst_req = 0; bus_ack = 0;
    #1;
    checks++;
    if (bus_req !== 1'b0 || inst_ready !== 1'b0) begin
      failures++; $display("FAIL fetch_release: bus_req=%b ready=%b want 0 0", bus_req, inst_ready);
    end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] r;
    r = $urandom;
    step();
    inst_req = 1; inst_addr = 32'hBFC00004;
    data_req = 1; data_we = 1; data_addr = 32'h80000010; data_wdata = 32'h12345678;
    step();
    bus_ack = 1;
    #1;
    checks++;
    if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h80000010 || bus_wdata !== 32'h12345678) begin
      failures++;
      $display("FAIL simul_data_first: req=%b we=%b addr=%h wdata=%h want 1 1 80000010 12345678", bus_req, bus_we, bus_addr, bus_wdata);
    end
    checks++;
    if (data_ready !== 1'b1 || inst_ready !== 1'b0 || inst_stall !== 1'b1) begin
      failures++;
      $display("FAIL simul_ready: dr=%b ir=%b istall=%b want 1 0 1", data_ready, inst_ready, inst_stall);
    end
    step();
    data_req = 0; bus_ack = 0;
    #1;
    checks++;
    if (bus_req !== 1'b0) begin
      failures++; $display("FAIL simul_gap: bus_req=%b want 0", bus_req);
    end
    step();
    bus_ack = 1; bus_rdata = r;
    #1;
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'hBFC00004 || bus_we !== 1'b0 || inst_ready !== 1'b1 || inst_rdata !== r) begin
      failures++;
      $display("FAIL simul_inst: req=%b addr=%h we=%b ir=%b rdata=%h want 1 bfc00004 0 1 %h", bus_req, bus_addr, bus_we, inst_ready, inst_rdata, r);
    end
    step();
    inst_req = 0; bus_ack = 0;
  endtask

  task automatic test_run_limit();
    int seq[$];
    int expSeq[6] = '{2, 2, 2, 2, 1, 2};
    step();
    inst_req = 1; inst_addr = 32'h00400000;
    data_req = 1; data_we = 0; data_addr = 32'h10000000;
    for (int c = 0; c < 80 && seq.size() < 6; c++) begin
      step();
      if (bus_req) begin
        bus_ack = 1;
        seq.push_back(bus_addr == 32'h10000000 ? 2 : 1);
      end else begin
        bus_ack = 0;
      end
    end
    step();
    inst_req = 0; data_req = 0; bus_ack = 0;
    step();
    checks++;
    if (seq.size() != 6) begin
      failures++; $display("FAIL run_limit_count: grants=%0d want 6", seq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (seq[i] != expSeq[i]) begin
          failures++; $display("FAIL run_limit_order[%0d]: port=%0d want %0d (1=inst 2=data)", i, seq[i], expSeq[i]);
        end
      end
    end
  endtask

  task automatic test_addr_hold();
    logic [DW-1:0] r;
    r = $urandom;
    step();
    data_req = 1; data_we = 0; data_addr = 32'h80000100; data_wdata = 32'h0;
    step();
    data_addr = 32'h80000200; data_we = 1; data_wdata = 32'hCAFEF00D;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (bus_req !== 1'b1 || bus_addr !== 32'h80000100 || bus_we !== 1'b0 || data_ready !== 1'b0) begin
        failures++;
        $display("FAIL addr_hold_wait%0d: req=%b addr=%h we=%b dr=%b want 1 80000100 0 0", c, bus_req, bus_addr, bus_we, data_ready);
      end
      step();
    end
    bus_ack = 1; bus_rdata = r;
    #1;
    checks++;
    if (bus_addr !== 32'h80000100 || data_ready !== 1'b1 || data_rdata !== r) begin
      failures++;
      $display("FAIL addr_hold_done: addr=%h dr=%b rdata=%h want 80000100 1 %h", bus_addr, data_ready, data_rdata, r);
    end
    step();
    data_req = 0; data_we = 0; bus_ack = 0;
  endtask

  task automatic test_reset_mid_grant();
    step();
    data_req = 1; data_we = 1; data_addr = 32'h80000040; data_wdata = 32'h55AA55AA;
    step();
    #1;
    checks++;
    if (bus_req !== 1'b1) begin
      failures++; $display("FAIL rst_mid_pre: bus_req=%b want 1", bus_req);
    end
    #1;
    rst = 1; bus_ack = 1;
    #1;
    checks++;
    if (bus_req !== 1'b0 || data_ready !== 1'b0 || bus_we !== 1'b0) begin
      failures++; $display("FAIL rst_mid_async: req=%b dr=%b we=%b want 0 0 0", bus_req, data_ready, bus_we);
    end
    step();
    data_req = 0; data_we = 0; bus_ack = 0; rst = 0;
    step();
    #1;
    checks++;
    if (bus_req !== 1'b0 || data_ready !== 1'b0 || data_stall !== 1'b0) begin
      failures++; $display("FAIL rst_mid_idle: req=%b dr=%b ds=%b want 0 0 0", bus_req, data_ready, data_stall);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    step();
    inst_req = 1; inst_addr = 32'hBFC00100; bus_ack = 0;
    for (int c = 1; c <= TO; c++) begin
      step();
      #1;
      if (c < TO) begin
        checks++;
        if (bus_err !== 1'b0 || inst_ready !== 1'b0 || bus_req !== 1'b1) begin
          failures++; $display("FAIL timeout_early%0d: err=%b ir=%b req=%b want 0 0 1", c, bus_err, inst_ready, bus_req);
        end
      end else begin
        checks++;
        if (bus_err !== 1'b1 || inst_ready !== 1'b1 || inst_rdata !== 32'hDEADBEEF) begin
          failures++; $display("FAIL timeout_abort: err=%b ir=%b rdata=%h want 1 1 deadbeef", bus_err, inst_ready, inst_rdata);
        end
      end
    end
    step();
    inst_req = 0;
    #1;
    checks++;
    if (bus_req !== 1'b0 || bus_err !== 1'b0) begin
      failures++; $display("FAIL timeout_idle: req=%b err=%b want 0 0", bus_req, bus_err);
    end
  endtask
`endif

  // Transaction-level reference: one owner at a time, a single idle cycle
  // between owners, data wins unless MAXR data grants already went by while
  // a fetch waited.
  task automatic test_random();
    int owner = 0;            // 0 none, 1 inst, 2 data
    int run = 0;
    logic [AW-1:0] eAddr = '0;
    logic eWe = 0;
    logic [DW-1:0] eWdata = '0;
    bit iSeen = 0, dSeen = 0;
    int waitCnt = 0;
    bit eIR, eDR;
    int fails0;
    step();
    idleInputs();
    rst = 1;
    step();
    rst = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (iSeen) begin
        if ($urandom_range(1) == 0) inst_req = 0;
        else inst_addr = $urandom;
        iSeen = 0;
      end else if (!inst_req && $urandom_range(2) == 0) begin
        inst_req = 1; inst_addr = $urandom;
      end
      if (dSeen) begin
        if ($urandom_range(1) == 0) data_req = 0;
        else begin data_addr = $urandom; data_we = $urandom_range(1); data_wdata = $urandom; end
        dSeen = 0;
      end else if (!data_req && $urandom_range(2) == 0) begin
        data_req = 1; data_addr = $urandom; data_we = $urandom_range(1); data_wdata = $urandom;
      end
      if (bus_req) begin
        waitCnt++;
        bus_ack = (waitCnt >= 8) || ($urandom_range(2) == 0);
        if (bus_ack) waitCnt = 0;
      end else begin
        waitCnt = 0;
        bus_ack = ($urandom_range(3) == 0);
      end
      bus_rdata = $urandom;
      #1;
      eIR = (owner == 1) && bus_ack;
      eDR = (owner == 2) && bus_ack;
      fails0 = failures;
      checks++;
      if (bus_req !== (owner != 0)) begin
        failures++; if (fails0 < 20) $display("FAIL rnd_busreq@%0d: %b want %b", cyc, bus_req, owner != 0);
      end
      checks++;
      if (inst_ready !== eIR || data_ready !== eDR) begin
        failures++; if (fails0 < 20) $display("FAIL rnd_ready@%0d: ir=%b dr=%b want %b %b", cyc, inst_ready, data_ready, eIR, eDR);
      end
      checks++;
      if (inst_stall !== (inst_req && !eIR) || data_stall !== (data_req && !eDR) || bus_err !== 1'b0) begin
        failures++; if (fails0 < 20) $display("FAIL rnd_stall@%0d: is=%b ds=%b err=%b", cyc, inst_stall, data_stall, bus_err);
      end
      if (owner != 0) begin
        checks++;
        if (bus_addr !== eAddr || bus_we !== eWe || (eWe && bus_wdata !== eWdata)) begin
          failures++;
          if (fails0 < 20) $display("FAIL rnd_bus@%0d: addr=%h we=%b wd=%h want %h %b %h", cyc, bus_addr, bus_we, bus_wdata, eAddr, eWe, eWdata);
        end
      end
      if (eIR) begin
        checks++;
        if (inst_rdata !== bus_rdata) begin
          failures++; if (fails0 < 20) $display("FAIL rnd_irdata@%0d: %h want %h", cyc, inst_rdata, bus_rdata);
        end
      end
      if (eDR && !eWe) begin
        checks++;
        if (data_rdata !== bus_rdata) begin
          failures++; if (fails0 < 20) $display("FAIL rnd_drdata@%0d: %h want %h", cyc, data_rdata, bus_rdata);
        end
      end
      iSeen = inst_ready;
      dSeen = data_ready;
      if (owner != 0) begin
        if (bus_ack) owner = 0;
      end else if (data_req && !(inst_req && run == MAXR)) begin
        owner = 2; eAddr = data_addr; eWe = data_we; eWdata = data_wdata;
        run = inst_req ? ((run + 1 > MAXR) ? MAXR : run + 1) : 0;
      end else if (inst_req) begin
        owner = 1; eAddr = inst_addr; eWe = 0; run = 0;
      end
    end
    step();
    idleInputs();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_run_limit();
    test_addr_hold();
    test_reset_mid_grant();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
